fsm3_rr_sched: RTL and testbench

FSM3_RR_SCHED -- requirements
Module: fsm3_rr_sched

---
 rtl/fsm3_rr_sched.sv | 124 ++++++++++++
 tb/tb_fsm3_rr_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm3_rr_sched.sv
// fsm3_rr_sched: one 4-state Moore FSM (A,B,C,D) shared by NCH serial
// channels. Each channel keeps its own state; a round-robin arbiter picks one
// requesting channel per cycle, advances its state with its pending bit and
// reports the Moore output one cycle later.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req[NCH]        channel has a pending bit (held until acked)
//   bit_in[NCH]     pending serial bit per channel
//   chan_clr[NCH]   per-channel clear of stored state (wins over a grant)
//   ack[NCH]        combinational one-hot grant; transfer = req & ack
//   out_valid       registered, high the cycle after a transfer
//   out_ch          registered channel index of the last transfer
//   out             registered Moore output (new state == D)
//   hit_cnt         saturating count of transfers that produced out=1
module fsm3_rr_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] bit_in,
  input  logic [NCH-1:0] chan_clr,
  output logic [NCH-1:0] ack,
  output logic           out_valid,
  output logic [CW-1:0]  out_ch,
  output logic           out,
  output logic [15:0]    hit_cnt
);

  localparam int unsigned HW = 16;
  localparam logic [HW-1:0] HIT_MAX = '1;

  typedef enum logic [1:0] {
    ST_A = 2'd0,
    ST_B = 2'd1,
    ST_C = 2'd2,
    ST_D = 2'd3
  } state_t;

  state_t          st_q [NCH];
  state_t          st_d [NCH];
  logic [CW-1:0]   last_q;
  logic [CW-1:0]   last_d;
  logic [NCH-1:0]  elig;
  logic            grant_vld;
  logic [CW-1:0]   grant_idx;
  state_t          grant_ns;
  logic [HW-1:0]   hit_d;

  // Shared next-state table
  function automatic state_t fsm_next(input state_t s, input logic b);
    state_t n;
    unique case (s)
      ST_A:    n = b ? ST_B : ST_A;
      ST_B:    n = b ? ST_B : ST_C;
      ST_C:    n = b ? ST_D : ST_A;
      ST_D:    n = b ? ST_B : ST_C;
      default: n = ST_A;
    endcase
    return n;
  endfunction

  // Round-robin search starting one past the last granted channel
  always_comb begin
    int unsigned   cand;
    logic [CW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    ack       = '0;
    elig      = req & ~chan_clr & {NCH{~reset}};
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= NCH) cand = cand - NCH;
      cand_idx = CW'(cand);
      if (!grant_vld && elig[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
    if (grant_vld) ack[grant_idx] = 1'b1;
  end

  // Next per-channel state, pointer and hit count
  always_comb begin
    st_d     = st_q;
    last_d   = last_q;
    hit_d    = hit_cnt;
    grant_ns = fsm_next(st_q[grant_idx], bit_in[grant_idx]);
    for (int unsigned i = 0; i < NCH; i++) begin
      if (chan_clr[i]) st_d[i] = ST_A;
    end
    if (grant_vld) begin
      st_d[grant_idx] = grant_ns;
      last_d          = grant_idx;
      if (grant_ns == ST_D && hit_cnt != HIT_MAX) hit_d = hit_cnt + HW'(1);
    end
  end

  // State and output registers; reset discards any in-flight transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) st_q[i] <= ST_A;
      last_q    <= CW'(NCH - 1);
      out_valid <= 1'b0;
      out_ch    <= '0;
      out       <= 1'b0;
      hit_cnt   <= '0;
    end else begin
      st_q      <= st_d;
      last_q    <= last_d;
      out_valid <= grant_vld;
      hit_cnt   <= hit_d;
      if (grant_vld) begin
        out_ch <= grant_idx;
        out    <= (grant_ns == ST_D);
      end
    end
  end

endmodule

// File: tb/tb_fsm3_rr_sched.sv
// Bench for fsm3_rr_sched: directed scenarios with hand-computed values,
// a randomized phase, and a saturation run, all shadowed by a behavioural
// model compared against the DUT on every falling edge.
module tb_fsm3_rr_sched;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] req;
  logic [NCH-1:0] bit_in;
  logic [NCH-1:0] chan_clr;
  logic [NCH-1:0] ack;
  logic           out_valid;
  logic [CW-1:0]  out_ch;
  logic           out;
  logic [15:0]    hit_cnt;

  fsm3_rr_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .bit_in   (bit_in),
    .chan_clr (chan_clr),
    .ack      (ack),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .out      (out),
    .hit_cnt  (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: states 0..3 = A..D, indexed [state][bit]
  int nxt [4][2] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};
  int mst [NCH];
  int mlast;
  bit mvalid;
  int mch;
  bit mout;
  int mhit;
  bit model_on = 1'b0;

  function automatic logic [NCH-1:0] model_ack();
    logic [NCH-1:0] a = '0;
    if (reset) return a;
    for (int k = 1; k <= NCH; k++) begin
      int c = (mlast + k) % NCH;
      if (req[c] && !chan_clr[c]) begin
        a[c] = 1'b1;
        return a;
      end
    end
    return a;
  endfunction

  always @(posedge clk) begin : model_upd
    logic [NCH-1:0] g;
    int ns;
    g = model_ack();
    if (reset) begin
      for (int i = 0; i < NCH; i++) mst[i] = 0;
      mlast = NCH - 1; mvalid = 0; mch = 0; mout = 0; mhit = 0;
      model_on = 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) if (chan_clr[i]) mst[i] = 0;
      mvalid = 0;
      for (int i = 0; i < NCH; i++) begin
        if (g[i]) begin
          ns = nxt[mst[i]][bit_in[i]];
          mst[i] = ns; mlast = i; mvalid = 1; mch = i; mout = (ns == 3);
          if (mout && mhit < 65535) mhit++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_ack",       32'(ack),       32'(model_ack()));
      chk("m_out_valid", 32'(out_valid), 32'(mvalid));
      chk("m_out_ch",    32'(out_ch),    32'(mch));
      chk("m_out",       32'(out),       32'(mout));
      chk("m_hit_cnt",   32'(hit_cnt),   32'(mhit));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; bit_in = '0; chan_clr = '0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req = '0; bit_in = '0; chan_clr = '0;
    // ack must stay low during reset even with requests
    cyc(); req = 4'hF;
    @(negedge clk); chk("rst_ack", 32'(ack), 32'd0);

    // Channel 0 alone sends 1,0,1 -> states B,C,D
    do_reset(); req = 4'b0001; bit_in = 4'b0001;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_hit",       32'(hit_cnt),   32'd0);
    chk("s1_ack",        32'(ack),       32'd1);
    cyc(); bit_in = 4'b0000;
    @(negedge clk); chk("s1_valid1", 32'(out_valid), 32'd1); chk("s1_out1", 32'(out), 32'd0);
    cyc(); bit_in = 4'b0001;
    @(negedge clk); chk("s1_out2", 32'(out), 32'd0);
    cyc(); req = '0; bit_in = '0;
    @(negedge clk); chk("s1_out3", 32'(out), 32'd1); chk("s1_hit", 32'(hit_cnt), 32'd1);
    cyc();
    @(negedge clk); chk("s1_idle_valid", 32'(out_valid), 32'd0); chk("s1_hold_out", 32'(out), 32'd1);

    // All four requesting: grant order 0,1,2,3,0,1
    do_reset(); req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("s2_ack", 32'(ack), 32'(1 << (k % 4)));
      if (k > 0) chk("s2_out_ch", 32'(out_ch), 32'((k - 1) % 4));
      cyc();
    end

    // Channels 1 and 2 interleaved, each sending 1,0,1
    do_reset(); req = 4'b0110;
    for (int k = 0; k < 6; k++) begin
      bit_in = ((k / 2) == 1) ? 4'b0000 : 4'b0110;
      @(negedge clk);
      chk("s3_ack", 32'(ack), (k % 2 == 0) ? 32'd2 : 32'd4);
      if (k == 5) chk("s3_ch1_d", 32'(out), 32'd1);
      cyc();
    end
    req = '0;
    @(negedge clk);
    chk("s3_out", 32'(out), 32'd1); chk("s3_ch", 32'(out_ch), 32'd2); chk("s3_hit", 32'(hit_cnt), 32'd2);

    // Channel 3 in C, cleared while requesting
    do_reset(); req = 4'b1000; bit_in = 4'b1000;
    cyc(); bit_in = 4'b0000;
    cyc(); chan_clr = 4'b1000; bit_in = 4'b1000;
    @(negedge clk); chk("s4_clr_ack", 32'(ack), 32'd0);
    cyc(); chan_clr = '0;
    @(negedge clk); chk("s4_ack", 32'(ack), 32'd8); chk("s4_novalid", 32'(out_valid), 32'd0);
    cyc(); req = '0;
    @(negedge clk); chk("s4_valid", 32'(out_valid), 32'd1); chk("s4_out_b", 32'(out), 32'd0);

    // Reset in a cycle where channel 2 would be granted into D
    do_reset(); req = 4'b0100; bit_in = 4'b0100;
    cyc(); bit_in = 4'b0000;
    cyc(); bit_in = 4'b0100;
    @(negedge clk); chk("s5_ack", 32'(ack), 32'd4);
    #1 reset = 1'b1;
    #1 chk("s5_rst_ack", 32'(ack), 32'd0);
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("s5_valid", 32'(out_valid), 32'd0); chk("s5_hit", 32'(hit_cnt), 32'd0); chk("s5_out", 32'(out), 32'd0);
    cyc(); req = '0;
    @(negedge clk); chk("s5_from_a", 32'(out), 32'd0); chk("s5_valid2", 32'(out_valid), 32'd1);
    cyc();

    // Random traffic, checked by the model
    for (int i = 0; i < 3000; i++) begin
      req      = 4'($urandom);
      bit_in   = 4'($urandom);
      chan_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      reset    = ($urandom_range(0, 199) == 0);
      cyc();
    end

    // Saturation: channel 0 alternates 1,0 -> a hit on every other transfer
    do_reset(); req = 4'b0001;
    for (int i = 0; i < 131081; i++) begin
      bit_in = {3'b000, (i % 2 == 0)};
      @(negedge clk);
      if (i == 131069) chk("s6_fffe", 32'(hit_cnt), 32'h0000_FFFE);
      if (i == 131071) chk("s6_ffff", 32'(hit_cnt), 32'h0000_FFFF);
      cyc();
    end
    req = '0;
    @(negedge clk);
    chk("s6_sat", 32'(hit_cnt), 32'h0000_FFFF);
    chk("s6_out", 32'(out), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
